// File: rtl/gpio_irq_pkg.sv
// gpio_irq_pkg: shared constants and helpers for the GPIO/interrupt peripheral.
//   - Register byte offsets inside the 32-byte window (word index = offset[4:2]).
//   - write_n size encodings used by the tinyQV data bus.
//   - Decoded bus request payload and a byte-lane mask helper.
package gpio_irq_pkg;

  localparam int unsigned BUS_DW = 32;
  localparam int unsigned BUS_AW = 28;

  localparam logic [4:0] OFF_OUT     = 5'h00;
  localparam logic [4:0] OFF_IN      = 5'h04;
  localparam logic [4:0] OFF_OE      = 5'h08;
  localparam logic [4:0] OFF_IRQ_EN  = 5'h0C;
  localparam logic [4:0] OFF_MODE    = 5'h10;
  localparam logic [4:0] OFF_POL     = 5'h14;
  localparam logic [4:0] OFF_PENDING = 5'h18;
  localparam logic [4:0] OFF_OUT_TGL = 5'h1C;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_NONE = 2'b11;

  // Decoded, in-window bus request.
  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [2:0] idx;
  } bus_req_t;

  // Bits of the 32-bit register touched by a write of the given size.
  function automatic logic [BUS_DW-1:0] byte_mask(input logic [1:0] wn);
    logic [BUS_DW-1:0] m;
    m = '0;
    case (wn)
      SZ_BYTE: m = 32'h0000_00FF;
      SZ_HALF: m = 32'h0000_FFFF;
      SZ_WORD: m = 32'hFFFF_FFFF;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: per-pin input synchroniser with edge detection.
//   clk, rstn   : clock, async active-low reset
//   pin_async   : raw pad inputs
//   s           : synchronised pin levels (SYNC_STAGES flops deep)
//   rise_c      : s went 0->1 since the previous cycle
//   fall_c      : s went 1->0 since the previous cycle
module gpio_sync_edge #(
  parameter int unsigned NUM_PINS    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_PINS-1:0] pin_async,
  output logic [NUM_PINS-1:0] s,
  output logic [NUM_PINS-1:0] rise_c,
  output logic [NUM_PINS-1:0] fall_c
);

  localparam int unsigned CHAIN_W = SYNC_STAGES * NUM_PINS;

  // Oldest stage sits in the top NUM_PINS bits of the chain.
  logic [CHAIN_W-1:0]  chain_q;
  logic [NUM_PINS-1:0] prev_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain_q <= '0;
      prev_q  <= '0;
    end else begin
      chain_q <= {chain_q[CHAIN_W-NUM_PINS-1:0], pin_async};
      prev_q  <= s;
    end
  end

  assign s      = chain_q[CHAIN_W-1 -: NUM_PINS];
  assign rise_c = s & ~prev_q;
  assign fall_c = ~s & prev_q;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: NUM_PINS GPIO with per-pin level/edge interrupts on the tinyQV bus.
//   clk, rstn        : clock, async active-low reset
//   addr             : bus address; 32-byte window at BASE_ADDR, index addr[4:2]
//   write_n, read_n  : access size / strobe (11 = idle)
//   data_in/data_out : write data / read data (read data valid with data_ready)
//   data_ready       : writes complete in the request cycle, reads one cycle later
//   gpio_in          : asynchronous pad inputs
//   gpio_out/gpio_oe : pad output values / output enables
//   irq              : registered OR of pending & irq_en
module gpio_irq_ctrl
  import gpio_irq_pkg::*;
#(
  parameter int unsigned NUM_PINS    = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [27:0] BASE_ADDR   = 28'h8000040
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [27:0]         addr,
  input  logic [1:0]          write_n,
  input  logic [1:0]          read_n,
  input  logic [31:0]         data_in,
  output logic [31:0]         data_out,
  output logic                data_ready,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oe,
  output logic                irq
);

  typedef logic [NUM_PINS-1:0] pins_t;

  logic     sel_c;
  bus_req_t req;
  pins_t    wmask_c, wdata_c, w1c_c;
  pins_t    s, rise_c, fall_c, edge_hit_c, pending_c;
  logic [BUS_DW-1:0] rdata_c;

  pins_t out_q, oe_q, en_q, mode_q, pol_q, edge_q;
  logic  irq_q, rd_pend_q;
  logic [BUS_DW-1:0] data_out_q;

  // addr[1:0] and data_in bits above NUM_PINS carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], data_in};

  gpio_sync_edge #(
    .NUM_PINS    (NUM_PINS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rstn      (rstn),
    .pin_async (gpio_in),
    .s         (s),
    .rise_c    (rise_c),
    .fall_c    (fall_c)
  );

  // Address decode; a write wins if a (illegal) read arrives with it.
  assign sel_c = (addr[27:5] == BASE_ADDR[27:5]);

  always_comb begin
    req     = '0;
    req.wr  = sel_c && (write_n != SZ_NONE);
    req.rd  = sel_c && (read_n != SZ_NONE) && !(write_n != SZ_NONE);
    req.idx = addr[4:2];
  end

  // Write lanes restricted to the implemented pins.
  assign wmask_c = NUM_PINS'(byte_mask(write_n));
  assign wdata_c = NUM_PINS'(data_in) & wmask_c;
  assign w1c_c   = (req.wr && (req.idx == OFF_PENDING[4:2])) ? wdata_c : '0;

  // Level pins report the live (polarity-adjusted) input; edge pins the latched bit.
  assign edge_hit_c = (rise_c & ~pol_q) | (fall_c & pol_q);
  assign pending_c  = (mode_q & edge_q) | (~mode_q & (s ^ pol_q));

  // Configuration and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q  <= '0;
      oe_q   <= '0;
      en_q   <= '0;
      mode_q <= '0;
      pol_q  <= '0;
    end else if (req.wr) begin
      case (req.idx)
        OFF_OUT[4:2]:     out_q  <= (out_q & ~wmask_c) | wdata_c;
        OFF_OE[4:2]:      oe_q   <= (oe_q & ~wmask_c) | wdata_c;
        OFF_IRQ_EN[4:2]:  en_q   <= (en_q & ~wmask_c) | wdata_c;
        OFF_MODE[4:2]:    mode_q <= (mode_q & ~wmask_c) | wdata_c;
        OFF_POL[4:2]:     pol_q  <= (pol_q & ~wmask_c) | wdata_c;
        OFF_OUT_TGL[4:2]: out_q  <= out_q ^ wdata_c;
        default: ;
      endcase
    end
  end

  // Edge latches: a new edge beats a same-cycle W1C; non-edge pins hold nothing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      edge_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      edge_q <= mode_q & ((edge_q & ~w1c_c) | edge_hit_c);
      irq_q  <= |(pending_c & en_q);
    end
  end

  // Read data select.
  always_comb begin
    rdata_c = '0;
    case (req.idx)
      OFF_OUT[4:2]:     rdata_c = BUS_DW'(out_q);
      OFF_IN[4:2]:      rdata_c = BUS_DW'(s);
      OFF_OE[4:2]:      rdata_c = BUS_DW'(oe_q);
      OFF_IRQ_EN[4:2]:  rdata_c = BUS_DW'(en_q);
      OFF_MODE[4:2]:    rdata_c = BUS_DW'(mode_q);
      OFF_POL[4:2]:     rdata_c = BUS_DW'(pol_q);
      OFF_PENDING[4:2]: rdata_c = BUS_DW'(pending_c);
      default:          rdata_c = '0;
    endcase
  end

  // One wait state on reads: capture in the request cycle, respond the next.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_pend_q  <= 1'b0;
      data_out_q <= '0;
    end else if (rd_pend_q) begin
      rd_pend_q  <= 1'b0;
    end else if (req.rd) begin
      rd_pend_q  <= 1'b1;
      data_out_q <= rdata_c;
    end
  end

  assign data_ready = req.wr | rd_pend_q;
  assign data_out   = data_out_q;
  assign gpio_out   = out_q;
  assign gpio_oe    = oe_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
`timescale 1ns/1ps
module tb_gpio_irq_ctrl;

  localparam int NP = 16;
  localparam int SS = 2;
  localparam logic [27:0] BASE   = 28'h8000040;
  localparam logic [27:0] A_OUT  = BASE + 28'h00;
  localparam logic [27:0] A_IN   = BASE + 28'h04;
  localparam logic [27:0] A_OE   = BASE + 28'h08;
  localparam logic [27:0] A_EN   = BASE + 28'h0C;
  localparam logic [27:0] A_MODE = BASE + 28'h10;
  localparam logic [27:0] A_POL  = BASE + 28'h14;
  localparam logic [27:0] A_PEND = BASE + 28'h18;
  localparam logic [27:0] A_TGL  = BASE + 28'h1C;
  localparam logic [1:0]  WORD   = 2'b10;

  typedef logic [NP-1:0] pv_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [27:0] addr = BASE;
  logic [1:0]  write_n = 2'b11;
  logic [1:0]  read_n = 2'b11;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        data_ready;
  pv_t         gpio_in = '0;
  pv_t         gpio_out, gpio_oe;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  gpio_irq_ctrl #(.NUM_PINS(NP), .SYNC_STAGES(SS), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .write_n(write_n), .read_n(read_n),
    .data_in(data_in), .data_out(data_out), .data_ready(data_ready),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    pv_t         out, oe, en, mode, pol, edg;
    logic        irq;
    logic        rdp;
    logic [31:0] dout;
  } mstate_t;

  mstate_t m = '{default: '0};
  pv_t     hist[$];   // gpio_in as seen at each past clock edge, newest first

  function automatic pv_t hist_at(input int i);
    return (i < hist.size()) ? hist[i] : '0;
  endfunction

  function automatic bit in_win(input logic [27:0] a);
    return a[27:5] == BASE[27:5];
  endfunction

  function automatic logic [31:0] size_bytes(input logic [1:0] wn);
    case (wn)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      2'b10:   return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic pv_t pending_of(input mstate_t c);
    pv_t s, p;
    s = hist_at(SS - 1);
    for (int i = 0; i < NP; i++)
      p[i] = c.mode[i] ? c.edg[i] : (s[i] ^ c.pol[i]);
    return p;
  endfunction

  function automatic logic [31:0] reg_value(input mstate_t c, input logic [2:0] idx);
    case (idx)
      3'd0:    return 32'(c.out);
      3'd1:    return 32'(hist_at(SS - 1));
      3'd2:    return 32'(c.oe);
      3'd3:    return 32'(c.en);
      3'd4:    return 32'(c.mode);
      3'd5:    return 32'(c.pol);
      3'd6:    return 32'(pending_of(c));
      default: return 32'h0;
    endcase
  endfunction

  function automatic mstate_t model_step(input mstate_t c);
    mstate_t    n;
    pv_t        s, p, pend, msk, w;
    logic [2:0] idx;
    bit         wr, rd;
    n    = c;
    s    = hist_at(SS - 1);
    p    = hist_at(SS);
    pend = pending_of(c);
    wr   = in_win(addr) && (write_n != 2'b11);
    rd   = in_win(addr) && (read_n != 2'b11) && !wr;
    idx  = addr[4:2];
    msk  = NP'(size_bytes(write_n));
    w    = NP'(data_in) & msk;
    n.irq = |(pend & c.en);
    for (int i = 0; i < NP; i++) begin
      bit hit;
      hit = c.pol[i] ? (p[i] && !s[i]) : (s[i] && !p[i]);
      if (!c.mode[i])                       n.edg[i] = 1'b0;
      else if (hit)                         n.edg[i] = 1'b1;
      else if (wr && idx == 3'd6 && w[i])   n.edg[i] = 1'b0;
    end
    if (c.rdp) n.rdp = 1'b0;
    else if (rd) begin
      n.rdp  = 1'b1;
      n.dout = reg_value(c, idx);
    end
    if (wr) begin
      case (idx)
        3'd0: n.out  = (c.out & ~msk) | w;
        3'd2: n.oe   = (c.oe & ~msk) | w;
        3'd3: n.en   = (c.en & ~msk) | w;
        3'd4: n.mode = (c.mode & ~msk) | w;
        3'd5: n.pol  = (c.pol & ~msk) | w;
        3'd7: n.out  = c.out ^ w;
        default: ;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m <= '{default: '0};
      hist.delete();
    end else begin
      m <= model_step(m);
      hist.push_front(gpio_in);
      if (hist.size() > SS + 1) void'(hist.pop_back());
    end
  end

  // Continuous comparison of every output against the model, mid low phase.
  always @(negedge clk) begin
    #2;
    check_eq("gpio_out", 32'(gpio_out), 32'(m.out));
    check_eq("gpio_oe", 32'(gpio_oe), 32'(m.oe));
    check_eq("irq", 32'(irq), 32'(m.irq));
    check_eq("data_ready", 32'(data_ready),
             32'((in_win(addr) && write_n != 2'b11) || m.rdp));
  end

  // ---------------- bus tasks ----------------
  task automatic bus_write(input logic [27:0] a, input logic [1:0] wn, input logic [31:0] d);
    @(negedge clk);
    addr = a; write_n = wn; data_in = d;
    #1 check_eq("wr_ready", 32'(data_ready), 32'(in_win(a)));
    @(posedge clk); #1;
    write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [27:0] a, input logic [1:0] rn, output logic [31:0] d);
    @(negedge clk);
    addr = a; read_n = rn;
    #1 check_eq("rd_wait", 32'(data_ready), 32'h0);
    @(posedge clk); #1;
    read_n = 2'b11;
    check_eq("rd_ready", 32'(data_ready), 32'(in_win(a)));
    d = data_out;
    if (in_win(a)) check_eq("rd_data_model", data_out, m.dout);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [27:0] a;
    int          op;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_eq("rst_gpio_out", 32'(gpio_out), 32'h0);
    check_eq("rst_gpio_oe", 32'(gpio_oe), 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);
    check_eq("rst_data_out", data_out, 32'h0);
    for (int i = 0; i < 8; i++) begin
      bus_read(BASE + 28'(i * 4), WORD, rd);
      check_eq("rst_reg", rd, 32'h0);
    end

    // Output, enable, toggle and partial writes.
    bus_write(A_OE, WORD, 32'h0000_00FF);
    bus_write(A_OUT, WORD, 32'h0000_00A5);
    bus_write(A_TGL, WORD, 32'h0000_000F);
    check_eq("oe_ff", 32'(gpio_oe), 32'h0000_00FF);
    check_eq("out_toggle", 32'(gpio_out), 32'h0000_00AA);
    bus_write(A_OUT, WORD, 32'h0000_1234);
    bus_write(A_OUT + 28'd2, 2'b00, 32'hFFFF_FF3C);
    check_eq("byte_write", 32'(gpio_out), 32'h0000_123C);
    bus_write(A_OUT, 2'b01, 32'hABCD_5678);
    check_eq("half_write", 32'(gpio_out), 32'h0000_5678);
    bus_write(A_OE, WORD, 32'hFFFF_FFFF);
    bus_read(A_OE, WORD, rd);
    check_eq("oe_upper_zero", rd, 32'h0000_FFFF);
    bus_write(A_OE, WORD, 32'h0000_00FF);

    // Edge interrupt latency and W1C.
    bus_write(A_MODE, WORD, 32'h1);
    bus_write(A_POL, WORD, 32'h0);
    bus_write(A_EN, WORD, 32'h1);
    @(negedge clk);
    gpio_in[0] = 1'b1;
    for (int k = 1; k <= SS + 2; k++) begin
      @(posedge clk); #1;
      check_eq("irq_latency", 32'(irq), 32'(k == SS + 2));
    end
    bus_read(A_PEND, WORD, rd);
    check_eq("pend_edge", rd, 32'h1);
    bus_write(A_PEND, WORD, 32'h1);
    bus_read(A_PEND, WORD, rd);
    check_eq("pend_w1c", rd, 32'h0);
    check_eq("irq_cleared", 32'(irq), 32'h0);

    // Falling edge ignored with POL=0; W1C coinciding with a rise loses.
    @(negedge clk);
    gpio_in[0] = 1'b0;
    repeat (6) @(negedge clk);
    bus_read(A_PEND, WORD, rd);
    check_eq("fall_ignored", rd, 32'h0);
    @(negedge clk);
    gpio_in[0] = 1'b1;
    repeat (SS - 1) @(negedge clk);
    bus_write(A_PEND, WORD, 32'h1);
    bus_read(A_PEND, WORD, rd);
    check_eq("edge_beats_w1c", rd, 32'h1);
    bus_write(A_PEND, WORD, 32'h1);
    bus_write(A_EN, WORD, 32'h0);

    // Level mode, low-active pin 3.
    bus_write(A_MODE, WORD, 32'h0);
    bus_write(A_POL, WORD, 32'h8);
    bus_read(A_PEND, WORD, rd);
    check_eq("level_low_pending", rd & 32'h8, 32'h8);
    bus_write(A_PEND, WORD, 32'h8);
    bus_read(A_PEND, WORD, rd);
    check_eq("level_w1c_no_effect", rd & 32'h8, 32'h8);
    @(negedge clk);
    gpio_in[3] = 1'b1;
    repeat (SS - 1) @(negedge clk);
    bus_read(A_PEND, WORD, rd);
    check_eq("level_follows_input", rd & 32'h8, 32'h0);

    // Outside the window: no ready, no state change.
    bus_read(BASE + 28'h20, WORD, rd);
    bus_write(BASE + 28'h20, WORD, 32'h0000_FFFF);
    bus_write(BASE - 28'h4, WORD, 32'h0000_FFFF);
    check_eq("outside_no_write", 32'(gpio_out), 32'h0000_5678);

    // Randomised traffic against the model.
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 2) == 0)
        gpio_in = gpio_in ^ (pv_t'(1) << $urandom_range(0, NP - 1));
      op = int'($urandom_range(0, 9));
      a  = BASE | 28'($urandom_range(0, 31));
      if (op <= 4) bus_write(a, 2'($urandom_range(0, 2)), $urandom);
      else if (op <= 7) bus_read(a, 2'($urandom_range(0, 2)), rd);
      else if (op == 8) begin
        @(negedge clk); @(posedge clk); #1;
      end else begin
        a = BASE ^ (28'd1 << $urandom_range(5, 27));
        if ($urandom_range(0, 1) == 0) bus_write(a, WORD, $urandom);
        else bus_read(a, WORD, rd);
      end
    end

    // Reset while a read is outstanding.
    bus_write(A_OUT, WORD, 32'h0000_00FF);
    bus_write(A_OE, WORD, 32'h0000_00FF);
    @(negedge clk);
    addr = A_IN; read_n = WORD;
    #3 rstn = 1'b0;
    #1 read_n = 2'b11;
    @(negedge clk); #1;
    check_eq("rst_rd_ready", 32'(data_ready), 32'h0);
    check_eq("rst_rd_out", 32'(gpio_out), 32'h0);
    check_eq("rst_rd_oe", 32'(gpio_oe), 32'h0);
    check_eq("rst_rd_irq", 32'(irq), 32'h0);
    check_eq("rst_rd_data", data_out, 32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_rd_dropped", 32'(data_ready), 32'h0);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
